// File: rtl/fft_sequencer.sv
// Frame controller for the 512-point radix-2 FFT: load, 9-level butterfly sweep
// over ping-pong banks, then unload. State, counters and phase flags are registered.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_LOAD   | writing input samples into bank 0
// S_PROC   | one butterfly per cycle, levels 0..8
// S_UNLOAD | reading results out of bank 1 under out_ready
module fft_sequencer #(
    parameter int N_POINTS = 512,
    parameter int N_LEVELS = 9
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       load,
    output logic       processing,
    output logic       done,
    output logic [8:0] load_address,
    output logic [8:0] fft_level,
    output logic [8:0] butterfly_iter,
    output logic [8:0] out_address,
    output logic       we_0,
    output logic       we_1,
    output logic       rd_bank,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       out_last,
    output logic       busy
);

    localparam logic [8:0] LAST_ADDR  = 9'(N_POINTS - 1);
    localparam logic [8:0] LAST_ITER  = 9'(N_POINTS / 2 - 1);
    localparam logic [8:0] LAST_LEVEL = 9'(N_LEVELS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PROC,
        S_UNLOAD
    } state_t;

    state_t     r_state;
    logic       r_load;
    logic       r_proc;
    logic       r_done;
    logic [8:0] r_load_addr;
    logic [8:0] r_level;
    logic [8:0] r_iter;
    logic [8:0] r_out_addr;
    logic       r_out_valid;
    logic       r_out_last;

    logic w_accept;
    logic w_take;
    logic w_iter_end;
    logic w_level_end;

    assign w_accept    = r_load & in_valid;
    assign w_take      = r_done & out_ready;
    assign w_iter_end  = (r_iter == LAST_ITER);
    assign w_level_end = (r_level == LAST_LEVEL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_load      <= 1'b0;
            r_proc      <= 1'b0;
            r_done      <= 1'b0;
            r_load_addr <= '0;
            r_level     <= '0;
            r_iter      <= '0;
            r_out_addr  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            // Read data lags the address by one cycle of synchronous RAM latency.
            r_out_valid <= w_take;
            r_out_last  <= w_take && (r_out_addr == LAST_ADDR);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_LOAD;
                        r_load      <= 1'b1;
                        r_load_addr <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_load_addr <= r_load_addr + 9'd1;
                        if (r_load_addr == LAST_ADDR) begin
                            r_state <= S_PROC;
                            r_load  <= 1'b0;
                            r_proc  <= 1'b1;
                            r_level <= '0;
                            r_iter  <= '0;
                        end
                    end
                end
                S_PROC: begin
                    if (w_iter_end) begin
                        r_iter <= '0;
                        if (w_level_end) begin
                            r_state    <= S_UNLOAD;
                            r_proc     <= 1'b0;
                            r_done     <= 1'b1;
                            r_level    <= '0;
                            r_out_addr <= '0;
                        end else begin
                            r_level <= r_level + 9'd1;
                        end
                    end else begin
                        r_iter <= r_iter + 9'd1;
                    end
                end
                S_UNLOAD: begin
                    if (w_take) begin
                        r_out_addr <= r_out_addr + 9'd1;
                        if (r_out_addr == LAST_ADDR) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_load  <= 1'b0;
                    r_proc  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Even levels read bank 0 and write bank 1; the final level (8) leaves results in bank 1.
    assign in_ready       = r_load;
    assign load           = r_load;
    assign processing     = r_proc;
    assign done           = r_done;
    assign busy           = r_load | r_proc | r_done;
    assign load_address   = r_load_addr;
    assign fft_level      = r_level;
    assign butterfly_iter = r_iter;
    assign out_address    = r_out_addr;
    assign rd_bank        = (r_proc & r_level[0]) | r_done;
    assign we_0           = w_accept | (r_proc & r_level[0]);
    assign we_1           = r_proc & ~r_level[0];
    assign out_valid      = r_out_valid;
    assign out_last       = r_out_last;

endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Top-level controller for the 512-point radix-2 FFT engine. It accepts a start pulse, streams 512 input samples into bank 0, then sweeps 9 butterfly levels of 256 butterflies each, ping-ponging between the two sample banks. It then streams the 512 results out of the final bank. It drives the load, processing and done strobes and the level, iteration and address counters consumed by the address-generation unit, plus the bank write enables.

## Interface
- `N_POINTS`, 512: transform length. Fixed; counters are 9 bits.
- `N_LEVELS`, 9: butterfly levels, log2(`N_POINTS`).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a frame. Sampled only in IDLE.
- `in_valid`  in  1  input sample present this cycle.
- `in_ready`  out  1  sequencer accepts a sample (LOAD state).
- `load`  out  1  high in LOAD.
- `processing`  out  1  high in PROC.
- `done`  out  1  high in UNLOAD.
- `load_address`  out  9  natural-order index of the next input sample.
- `fft_level`  out  9  current level 0..8; bits [8:4] are always 0.
- `butterfly_iter`  out  9  current butterfly 0..255; bit 8 is always 0.
- `out_address`  out  9  result index being read.
- `we_0`  out  1  write strobe for bank 0.
- `we_1`  out  1  write strobe for bank 1.
- `rd_bank`  out  1  bank feeding the butterfly or output path.
- `out_ready`  in  1  downstream accepts a result.
- `out_valid`  out  1  result data (1-cycle synchronous RAM read) valid this cycle.
- `out_last`  out  1  qualifies the out_valid for index 511.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, LOAD, PROC, UNLOAD. No other states.
  - IDLE -> LOAD on `start`.
  - LOAD -> PROC after the 512th accepted sample.
  - PROC -> UNLOAD after level 8, iteration 255.
  - UNLOAD -> IDLE after `out_address` 511 is accepted.
- LOAD:
  - `in_ready` = 1; a sample is accepted when `in_valid` is high.
  - `we_0` = `in_valid`; `we_1` = 0.
  - `load_address` increments per accepted sample and wraps 511 -> 0 on the state exit.
  - No stall limit; `in_valid` low simply holds the counter.
- PROC:
  - One butterfly per cycle, no stalls.
  - `butterfly_iter` counts 0..255. At 255 it wraps to 0 and `fft_level` increments.
  - `rd_bank` = `fft_level[0]`.
  - `we_1` = ~`fft_level[0]`; `we_0` = `fft_level[0]`. The write bank is always the opposite of `rd_bank`.
  - Exactly 2304 PROC cycles. Results land in bank 1 because level 8 reads bank 0.
- UNLOAD:
  - `rd_bank` = 1; `we_0` = `we_1` = 0.
  - `out_address` advances only when `out_ready` = 1.
  - `out_valid` is the registered (UNLOAD & `out_ready`); `out_last` is the registered (UNLOAD & `out_ready` & `out_address` == 511).
- `start` outside IDLE is ignored. `in_valid` outside LOAD is ignored and `we_0` stays 0.
- Counters reset to 0 on entering their state. `fft_level` and `butterfly_iter` hold 0 outside PROC.

## Timing
- Reset (asynchronous, `reset_n` low):
  - State goes to IDLE.
  - All counters are 0.
  - All outputs are 0, including `rd_bank`, `out_valid` and `out_last`.
- Reset asserted mid-frame aborts immediately. No write strobe is issued after reset asserts.
- `start` high at edge k puts `load` = 1 from cycle k+1.
- The 512th sample accepted at edge m puts `processing` = 1 from m+1, with level 0, iteration 0.
- The final butterfly is at cycle p. `done` = 1 from p+1, with `out_address` = 0.
- `out_valid` is high the cycle after each address is accepted. The final `out_valid`/`out_last` pulse occurs in the first IDLE cycle.
- Minimum frame length with no stalls: 1 + 512 + 2304 + 512 cycles from `start`.
- `start` asserted in the same cycle as the final `out_valid` is honoured, because the state is already IDLE.

## Test plan
- Reset then idle: hold `reset_n` = 0, release, no `start` for 20 cycles. Every output stays 0 and `busy` = 0.
- Back-to-back load: pulse `start`, then `in_valid` = 1 for 512 cycles.
  - `load_address` 0..511 with `we_0` high each cycle.
  - `processing` rises exactly one cycle after the 512th sample.
- Gapped load: `in_valid` toggled 1,0,1,0.
  - `load_address` advances only on accepted cycles.
  - LOAD lasts 1024 cycles; `we_1` never asserts.
- Processing sweep:
  - `fft_level` steps 0..8, each level exactly 256 cycles.
  - `rd_bank`/`we_1` = 0/1 at level 0 and 1/0 at level 1.
  - `done` rises after 2304 cycles.
- Backpressured unload: `out_ready` pattern 1,1,0,1.
  - `out_valid` follows accepted addresses by one cycle.
  - `out_last` pulses once, with index 511.
  - Returns to IDLE.
- Abort and ignore: assert `reset_n` = 0 at PROC level 4 and release. The sequencer is in IDLE. A fresh frame then completes normally. `start` pulses issued during LOAD are ignored.
